// File: rtl/fpcvt_sequencer_if.sv
// fpcvt_sequencer_if: sample-in / result-out handshake bundle for the fp converter
interface fpcvt_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [2:0]  exp_out;
  logic [3:0]  sig_out;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, sign, exp_out, sig_out
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, sign, exp_out, sig_out
  );
endinterface

// File: rtl/fpcvt_sequencer.sv
// fpcvt_sequencer: multi-cycle 12b two's-complement to 8b float (sign, 3b exp, 4b sig) converter
module fpcvt_sequencer #(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  fpcvt_sequencer_if.slave  bus,
  output logic              busy_o
);
  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;
  state_t      state_q;
  logic [11:0] mag_q;
  logic [2:0]  cnt_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
  logic        sign_q;
  logic [2:0]  exp_q;
  logic [3:0]  sig_q;
  logic [4:0]  s5;
  assign s5 = {1'b0, mag_q[10:7]} + {4'd0, ROUND_EN & mag_q[6]};
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sign      = sign_q;
  assign bus.exp_out   = exp_q;
  assign bus.sig_out   = sig_q;
  assign busy_o        = busy_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= 12'd0;
      cnt_q       <= 3'd7;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= 3'd0;
      sig_q       <= 4'd0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          mag_q      <= bus.in_data;
          sign_q     <= bus.in_data[11];
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= ABS;
        end
        ABS: begin
          mag_q   <= !sign_q ? mag_q : mag_q == 12'h800 ? 12'h7FF : -mag_q;
          cnt_q   <= 3'd7;
          state_q <= NORM;
        end
        NORM: if (mag_q[10] || cnt_q == 3'd0) state_q <= ROUND;
        else begin
          mag_q <= mag_q << 1;
          cnt_q <= cnt_q - 3'd1;
        end
        ROUND: begin
          sig_q       <= !s5[4] ? s5[3:0] : cnt_q != 3'd7 ? 4'd8 : 4'd15;
          exp_q       <= !s5[4] || cnt_q == 3'd7 ? cnt_q : cnt_q + 3'd1;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpcvt_sequencer.sv
// tb_fpcvt_sequencer: directed vectors against rounding and truncating converter instances
module tb_fpcvt_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = 12'd0;
  logic        out_ready = 1'b1;
  logic        busy0, busy1;
  int          vectors = 0;
  int          miscompares = 0;
  fpcvt_sequencer_if b0 ();
  fpcvt_sequencer_if b1 ();
  assign b0.in_valid  = in_valid;
  assign b0.in_data   = in_data;
  assign b0.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.in_data   = in_data;
  assign b1.out_ready = out_ready;
  fpcvt_sequencer #(.ROUND_EN(1'b1)) u_rnd (.clk(clk), .rst(rst), .bus(b0), .busy_o(busy0));
  fpcvt_sequencer #(.ROUND_EN(1'b0)) u_trn (.clk(clk), .rst(rst), .bus(b1), .busy_o(busy1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic idle_state(input string tag);
    chk({tag, " in_ready"}, b0.in_ready, 1);
    chk({tag, " out_valid"}, b0.out_valid, 0);
    chk({tag, " busy"}, busy0, 0);
    chk({tag, " sign"}, b0.sign, 0);
    chk({tag, " exp"}, b0.exp_out, 0);
    chk({tag, " sig"}, b0.sig_out, 0);
    chk({tag, " trn out_valid"}, b1.out_valid, 0);
  endtask
  task automatic apply(input string tag, input logic [11:0] d, input int k, input logic s,
                       input logic [2:0] e, input logic [3:0] g, input logic [2:0] et, input logic [3:0] gt);
    int n;
    @(negedge clk);
    chk({tag, " in_ready"}, b0.in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 1;
    while (!b0.out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, " latency"}, n, k + 4);
    chk({tag, " sign"}, b0.sign, s);
    chk({tag, " exp"}, b0.exp_out, e);
    chk({tag, " sig"}, b0.sig_out, g);
    chk({tag, " trn valid"}, b1.out_valid, 1);
    chk({tag, " trn sign"}, b1.sign, s);
    chk({tag, " trn exp"}, b1.exp_out, et);
    chk({tag, " trn sig"}, b1.sig_out, gt);
  endtask
  task automatic handshake(input string tag);
    @(posedge clk);
    #1;
    chk({tag, " out_valid drop"}, b0.out_valid, 0);
    chk({tag, " in_ready back"}, b0.in_ready, 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 idle_state("reset");
    @(negedge clk) rst = 1'b0;
    apply("7C1", 12'h7C1, 0, 1'b0, 3'd7, 4'd15, 3'd7, 4'd15);
    handshake("7C1");
    apply("46", 12'd46, 5, 1'b0, 3'd2, 4'd12, 3'd2, 4'd11);
    handshake("46");
    apply("-46", 12'hFD2, 5, 1'b1, 3'd2, 4'd12, 3'd2, 4'd11);
    handshake("-46");
    apply("62", 12'd62, 5, 1'b0, 3'd3, 4'd8, 3'd2, 4'd15);
    handshake("62");
    apply("zero", 12'h000, 7, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0);
    handshake("zero");
    apply("800", 12'h800, 0, 1'b1, 3'd7, 4'd15, 3'd7, 4'd15);
    handshake("800");
    out_ready = 1'b0;
    apply("stall", 12'd46, 5, 1'b0, 3'd2, 4'd12, 3'd2, 4'd11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 12'h123;
      @(posedge clk);
      #1;
      chk("stall out_valid", b0.out_valid, 1);
      chk("stall in_ready", b0.in_ready, 0);
      chk("stall busy", busy0, 1);
      chk("stall exp", b0.exp_out, 2);
      chk("stall sig", b0.sig_out, 12);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    handshake("stall");
    @(posedge clk);
    #1 chk("stall no accept busy", busy0, 0);
    @(negedge clk);
    in_data  = 12'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1 idle_state("midrst");
    @(negedge clk) rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 chk("midrst no valid", b0.out_valid, 0);
    end
    apply("5", 12'd5, 7, 1'b0, 3'd0, 4'd5, 3'd0, 4'd5);
    handshake("5");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
